dst_reg_pipe: RTL and testbench
===============================

// Module: dst_reg_pipe
// PURPOSE
//  Parametrised successor to the 2:1 destination-register select mux.
//  - Selects one of NSEL WIDTH-bit candidates (rt / rd / link reg 31 in the default build).
//  - Carries the chosen destination register ID, with a valid bit, through DEPTH pipeline stages
//    (EX/MEM/WB), honouring stall and flush.
//  - Exposes per-stage match flags against two source-register queries, for forwarding and
//    hazard detection in the ID stage.
// PARAMETERS
//  WIDTH        5  register-ID width in bits
//  NSEL         3  number of candidate inputs (>=2)
//  DEPTH        3  number of pipeline stages carried (>=1)
//  ZERO_IS_NULL 1  1: ID 0 is never a real destination (forced invalid, never hits)
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            synchronous, active-high reset
//  in_data     in   NSEL*WIDTH   candidate IDs; candidate k = in_data[k*WIDTH +: WIDTH]
//  sel         in   SELW         candidate select; SELW = (NSEL>1) ? $clog2(NSEL) : 1
//  in_valid    in   1            instruction in ID writes a register
//  stall       in   1            freeze the whole pipe this cycle
//  flush       in   1            insert a bubble into stage 0
//  query_a     in   WIDTH        source register A (rs) to compare
//  query_b     in   WIDTH        source register B (rt) to compare
//  stage_data  out  DEPTH*WIDTH  registered ID per stage; stage i = [i*WIDTH +: WIDTH]
//  stage_valid out  DEPTH        registered valid per stage
//  out_data    out  WIDTH        = stage DEPTH-1 data (WB destination)
//  out_valid   out  1            = stage_valid[DEPTH-1]
//  hit_a       out  DEPTH        combinational: stage i valid and matches query_a
//  hit_b       out  DEPTH        combinational: stage i valid and matches query_b
// BEHAVIOUR
//  - Reset: when rst=1 at a clock edge, every stage_data <= 0 and every stage_valid <= 0.
//    rst overrides stall and flush. hit_* are 0 while stages are invalid.
//  - Mux: m = candidate[sel].
//    - sel >= NSEL: m = 0 and the captured valid is 0.
//  - Captured valid cv = in_valid & (sel<NSEL) & ~(ZERO_IS_NULL & m==0).
//  - Per clock edge (rst=0), evaluated in priority order:
//    - stall=1, flush=0: all stages hold.
//    - stall=1, flush=1: stage 0 valid <= 0 and data holds; stages 1..DEPTH-1 hold.
//    - stall=0, flush=1: stage 0 <= {0, valid 0}; stage i <= stage i-1 for i>=1.
//    - stall=0, flush=0: stage 0 <= {m, cv}; stage i <= stage i-1.
//  - Latency: an ID captured at edge n is in stage k after edge n+k (no stalls).
//    out_data/out_valid show it after edge n+DEPTH-1.
//  - Bubbles keep data 0. Invalid stages are ignored by all consumers.
//  - hit_a[i] = stage_valid[i] & (stage_data[i]==query_a) & ~(ZERO_IS_NULL & query_a==0).
//    hit_b is identical, using query_b.
//    Both are pure combinational and are valid in the same cycle; no priority encoding here
//    (the consumer picks the youngest stage).
//  - Width rules: no arithmetic. Compares are exact WIDTH-bit equality.
//  - Mid-operation reset: rst clears the pipe in one edge; in-flight IDs are discarded.
// STRUCTURE
//  - Shared package/include (pipe_defs):
//    - REG_W = 5
//    - REG_ZERO = 5'd0, REG_RA = 5'd31
//    - RD_SEL_RT = 0, RD_SEL_RD = 1, RD_SEL_RA = 2
//  - One sub-module: mux_n. Parametrised N:1, W-bit combinational mux with an out-of-range
//    flag, used for the candidate select.
//  - Stage registers and hit compares are generate loops in this module.
// TESTING (WIDTH=5, NSEL=3, DEPTH=3, ZERO_IS_NULL=1 unless stated)
//  1. Reset: assert rst 2 cycles with stall=1, flush=1 -> all stage_valid=0, stage_data=0,
//     hit_a=hit_b=3'b000.
//  2. Flow: in_data={31,12,8}; sel=0,1,2 on successive cycles, in_valid=1 ->
//     - stage 0 shows 8, 12, 31;
//     - out_data=8 two edges after the first capture;
//     - then out_data=12, then out_data=31.
//  3. Stall/flush: capture 9; stall for 2 cycles -> stages frozen.
//     Then flush=1 with stall=0 -> stage0 valid=0 and 9 moves to stage 1.
//     stall=1 with flush=1 -> only stage0 valid cleared.
//  4. Hazard: stages hold {7,7,3}, all valid, query_a=7, query_b=3 ->
//     hit_a=3'b011, hit_b=3'b100. query_a=0 -> hit_a=0.
//  5. Edge inputs:
//     - sel=3 -> stage 0 valid=0, data=0.
//     - candidate ID 0 with in_valid=1 -> valid=0.
//     - With ZERO_IS_NULL=0 -> valid=1 and query 0 hits.
//  6. Mid-flight reset: 3 valid IDs in flight, rst for 1 cycle -> all cleared next edge.
//     Next capture then flows normally.

Source files
------------

// File: rtl/dst_reg_pipe_pkg.sv
// Shared pipeline register-ID definitions: ID width, fixed IDs and destination-select codes.
package dst_reg_pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  localparam int RD_SEL_RT = 0;
  localparam int RD_SEL_RD = 1;
  localparam int RD_SEL_RA = 2;

  typedef logic [REG_W-1:0] reg_id_t;

endpackage

// File: rtl/dst_reg_pipe_mux.sv
// N:1 W-bit combinational mux, zero latency, no flow control.
// An out-of-range select yields zero data and raises oor.
module mux_n #(
  parameter int N  = 3,
  parameter int W  = 5,
  parameter int SW = 2
) (
  input  logic [N*W-1:0] in_data,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out,
  output logic           oor
);

  always_comb begin
    out = '0;
    oor = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        out = in_data[k*W +: W];
        oor = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dst_reg_pipe.sv
// Destination-register ID pipeline: captured ID reaches stage k after k edges; stall freezes all stages.
// Per-stage hit flags are combinational so the ID stage can forward or interlock in the same cycle.
module dst_reg_pipe
  import dst_reg_pipe_pkg::*;
#(
  parameter int WIDTH        = REG_W,
  parameter int NSEL         = 3,
  parameter int DEPTH        = 3,
  parameter int ZERO_IS_NULL = 1,
  localparam int SELW        = (NSEL > 1) ? $clog2(NSEL) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSEL*WIDTH-1:0]  in_data,
  input  logic [SELW-1:0]        sel,
  input  logic                   in_valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       query_a,
  input  logic [WIDTH-1:0]       query_b,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  output logic [DEPTH-1:0]       hit_a,
  output logic [DEPTH-1:0]       hit_b
);

  logic [WIDTH-1:0] m;
  logic             oor;
  logic             m_null;
  logic             cv;
  logic             qa_null;
  logic             qb_null;

  logic [WIDTH-1:0] sdat [DEPTH];
  logic             svld [DEPTH];

  mux_n #(
    .N  (NSEL),
    .W  (WIDTH),
    .SW (SELW)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .out     (m),
    .oor     (oor)
  );

  // Register 0 is hard-wired, so it never creates a dependency
  assign m_null  = (ZERO_IS_NULL != 0) && (m == '0);
  assign qa_null = (ZERO_IS_NULL != 0) && (query_a == '0);
  assign qb_null = (ZERO_IS_NULL != 0) && (query_b == '0);
  assign cv      = in_valid & ~oor & ~m_null;

  always_ff @(posedge clk) begin
    if (rst) begin
      sdat[0] <= '0;
      svld[0] <= 1'b0;
    end else if (stall) begin
      if (flush) svld[0] <= 1'b0;
    end else if (flush) begin
      sdat[0] <= '0;
      svld[0] <= 1'b0;
    end else begin
      sdat[0] <= m;
      svld[0] <= cv;
    end
  end

  for (genvar i = 1; i < DEPTH; i++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        sdat[i] <= '0;
        svld[i] <= 1'b0;
      end else if (!stall) begin
        sdat[i] <= sdat[i-1];
        svld[i] <= svld[i-1];
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_out
    assign stage_data[i*WIDTH +: WIDTH] = sdat[i];
    assign stage_valid[i]               = svld[i];
    assign hit_a[i] = svld[i] & (sdat[i] == query_a) & ~qa_null;
    assign hit_b[i] = svld[i] & (sdat[i] == query_b) & ~qb_null;
  end

  assign out_data  = sdat[DEPTH-1];
  assign out_valid = svld[DEPTH-1];

endmodule

// File: tb/tb_dst_reg_pipe.sv
// Directed and random stimulus for dst_reg_pipe, with ZERO_IS_NULL=1 and =0 builds checked against a reference model.
module tb_dst_reg_pipe;
  import dst_reg_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [1:0]  sel;
  logic [14:0] in_data;
  logic [4:0]  qa, qb;

  logic [14:0] sd0, sd1;
  logic [2:0]  sv0, sv1, ha0, ha1, hb0, hb1;
  logic [4:0]  od0, od1;
  logic        ov0, ov1;

  int total = 0;
  int bad   = 0;

  // Reference state, index [build][stage]; build 0 = ZERO_IS_NULL=1, build 1 = ZERO_IS_NULL=0
  logic [4:0] md [2][3];
  logic       mv [2][3];

  always #5 clk = ~clk;

  dst_reg_pipe #(.WIDTH(5), .NSEL(3), .DEPTH(3), .ZERO_IS_NULL(1)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .query_a(qa), .query_b(qb),
    .stage_data(sd0), .stage_valid(sv0), .out_data(od0), .out_valid(ov0),
    .hit_a(ha0), .hit_b(hb0)
  );

  dst_reg_pipe #(.WIDTH(5), .NSEL(3), .DEPTH(3), .ZERO_IS_NULL(0)) u_dut_z (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .query_a(qa), .query_b(qb),
    .stage_data(sd1), .stage_valid(sv1), .out_data(od1), .out_valid(ov1),
    .hit_a(ha1), .hit_b(hb1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge using the currently driven inputs
  task automatic model_edge();
    logic [4:0] m;
    logic       cv;
    for (int z = 0; z < 2; z++) begin
      m  = (sel < 2'd3) ? in_data[sel*5 +: 5] : 5'd0;
      cv = in_valid && (sel < 2'd3) && !(z == 0 && m == 5'd0);
      if (rst) begin
        for (int i = 0; i < 3; i++) begin md[z][i] = 5'd0; mv[z][i] = 1'b0; end
      end else if (stall) begin
        if (flush) mv[z][0] = 1'b0;
      end else begin
        for (int i = 2; i > 0; i--) begin md[z][i] = md[z][i-1]; mv[z][i] = mv[z][i-1]; end
        md[z][0] = flush ? 5'd0 : m;
        mv[z][0] = flush ? 1'b0 : cv;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [14:0] esd;
    logic [2:0]  esv, eha, ehb;
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 3; i++) begin
        esd[i*5 +: 5] = md[z][i];
        esv[i] = mv[z][i];
        eha[i] = mv[z][i] && md[z][i] == qa && !(z == 0 && qa == 5'd0);
        ehb[i] = mv[z][i] && md[z][i] == qb && !(z == 0 && qb == 5'd0);
      end
      chk({tag, z ? "/z0 stage_data" : "/stage_data"},   z ? sd1 : sd0, esd);
      chk({tag, z ? "/z0 stage_valid" : "/stage_valid"}, z ? sv1 : sv0, esv);
      chk({tag, z ? "/z0 out_data" : "/out_data"},       z ? od1 : od0, md[z][2]);
      chk({tag, z ? "/z0 out_valid" : "/out_valid"},     z ? ov1 : ov0, mv[z][2]);
      chk({tag, z ? "/z0 hit_a" : "/hit_a"},             z ? ha1 : ha0, eha);
      chk({tag, z ? "/z0 hit_b" : "/hit_b"},             z ? hb1 : hb0, ehb);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic st, input logic fl,
                      input logic iv, input logic [1:0] s, input logic [14:0] d,
                      input logic [4:0] a, input logic [4:0] b);
    rst = r; stall = st; flush = fl; in_valid = iv; sel = s; in_data = d; qa = a; qb = b;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [14:0] d;
    logic [4:0]  c [3];
    rst = 1'b1; stall = 1'b1; flush = 1'b1; in_valid = 1'b0; sel = 2'd0;
    in_data = '0; qa = '0; qb = '0;
    @(posedge clk);
    #1;

    // Reset while stall and flush are also asserted
    step("reset1", 1, 1, 1, 1, 2'd0, {5'd31, 5'd12, 5'd8}, 5'd8, 5'd12);
    step("reset2", 1, 1, 1, 1, 2'd1, {5'd31, 5'd12, 5'd8}, 5'd8, 5'd12);
    chk("reset valid const", sv0, 3'b000);
    chk("reset data const", sd0, 15'd0);
    chk("reset hit_a const", ha0, 3'b000);

    // Flow: 8, 12, 31 through the pipe
    d = {REG_RA, 5'd12, 5'd8};
    step("flow0", 0, 0, 0, 1, 2'(RD_SEL_RT), d, 5'd8, 5'd31);
    chk("flow stage0=8", sd0[4:0], 5'd8);
    step("flow1", 0, 0, 0, 1, 2'(RD_SEL_RD), d, 5'd8, 5'd31);
    step("flow2", 0, 0, 0, 1, 2'(RD_SEL_RA), d, 5'd8, 5'd31);
    chk("flow out=8", od0, 5'd8);
    step("flow3", 0, 0, 0, 0, 2'd0, d, 5'd12, 5'd31);
    chk("flow out=12", od0, 5'd12);
    step("flow4", 0, 0, 0, 0, 2'd0, d, 5'd12, 5'd31);
    chk("flow out=31", od0, 5'd31);

    // Stall and flush interplay
    d = {5'd1, 5'd2, 5'd9};
    step("cap9", 0, 0, 0, 1, 2'd0, d, 5'd9, 5'd0);
    step("stall1", 0, 1, 0, 1, 2'd1, d, 5'd9, 5'd0);
    step("stall2", 0, 1, 0, 1, 2'd1, d, 5'd9, 5'd0);
    chk("stall holds 9", sd0[4:0], 5'd9);
    step("flush", 0, 0, 1, 1, 2'd1, d, 5'd9, 5'd0);
    chk("flush 9 to stage1", {sv0[1:0], sd0[9:5]}, {2'b10, 5'd9});
    step("cap2", 0, 0, 0, 1, 2'd1, d, 5'd2, 5'd9);
    step("stall_flush", 0, 1, 1, 1, 2'd0, d, 5'd2, 5'd9);
    chk("stall_flush stage0 data kept", {sv0[0], sd0[4:0]}, {1'b0, 5'd2});

    // Hazard: stages {7,7,3}
    d = {5'd0, 5'd7, 5'd3};
    step("hz0", 0, 0, 0, 1, 2'd0, d, 5'd7, 5'd3);
    step("hz1", 0, 0, 0, 1, 2'd1, d, 5'd7, 5'd3);
    step("hz2", 0, 0, 0, 1, 2'd1, d, 5'd7, 5'd3);
    chk("hazard hit_a", ha0, 3'b011);
    chk("hazard hit_b", hb0, 3'b100);
    step("hz3", 0, 1, 0, 0, 2'd0, d, 5'd0, 5'd3);
    chk("hazard query0", ha0, 3'b000);

    // Edge inputs
    step("sel3", 0, 0, 0, 1, 2'd3, {5'd4, 5'd5, 5'd6}, 5'd0, 5'd0);
    chk("sel3 stage0", {sv0[0], sd0[4:0]}, 6'd0);
    step("cand0", 0, 0, 0, 1, 2'd0, {5'd4, 5'd5, 5'd0}, 5'd0, 5'd5);
    chk("cand0 invalid", sv0[0], 1'b0);
    chk("cand0 z0 valid", sv1[0], 1'b1);
    chk("cand0 z0 query hit", ha1[0], 1'b1);

    // Mid-flight reset
    d = {5'd20, 5'd21, 5'd22};
    step("mf0", 0, 0, 0, 1, 2'd0, d, 5'd21, 5'd20);
    step("mf1", 0, 0, 0, 1, 2'd1, d, 5'd21, 5'd20);
    step("mf2", 0, 0, 0, 1, 2'd2, d, 5'd21, 5'd20);
    step("mf_rst", 1, 0, 0, 1, 2'd2, d, 5'd21, 5'd20);
    chk("mf cleared", {sv0, sv1}, 6'd0);
    step("mf_cap", 0, 0, 0, 1, 2'd1, {5'd1, 5'd12, 5'd3}, 5'd12, 5'd0);
    step("mf_f1", 0, 0, 0, 0, 2'd0, d, 5'd12, 5'd0);
    step("mf_f2", 0, 0, 0, 0, 2'd0, d, 5'd12, 5'd0);
    chk("mf out=12", {ov0, od0}, {1'b1, 5'd12});

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) c[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      step("rand",
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) != 0,
           2'($urandom_range(0, 3)),
           {c[2], c[1], c[0]},
           $urandom_range(0, 1) ? md[0][$urandom_range(0, 2)] : 5'($urandom),
           $urandom_range(0, 1) ? md[1][$urandom_range(0, 2)] : 5'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
